// File: rtl/wb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_fifo (with its serial engine, uart)
// Purpose  : Multi-channel Wishbone UART. Each channel wraps a uart core with
//            RX/TX FIFOs, sticky error flags, interrupt enables and a FIFO
//            flush. All channels share one Wishbone slave and one IRQ line.
// Ports    : clk, reset (async, active high)
//            wb_stb_i/wb_cyc_i/wb_we_i/wb_adr_i/wb_sel_i/wb_dat_i -> slave in
//            wb_ack_o/wb_dat_o                                -> slave out
//            uart_rxd[CHANNELS] in, uart_txd[CHANNELS] out, irq_o out
// Register map (channel n = adr[7:4], register = adr[3:2]):
//            0x0 STATUS  [7]txovf [6]rxovf [5]rxerr (W1C) [3]tx_full
//                        [2]tx_empty [1]rx_full [0]rx_not_empty
//            0x4 DATA    read pops RX FIFO, write pushes TX FIFO
//            0x8 CTRL    [0]rxie [1]txie [2]errie, [7]flush (write only)
//            0xC LEVEL   [7:4] TX count, [3:0] RX count (saturating at 15)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// uart: 8N1 serial engine. rx_avail stays high until rx_ack; tx_busy rises
// one cycle after tx_wr and falls after the stop bit has been sent.
// ----------------------------------------------------------------------------
module uart #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int          c_DIV  = clk_freq / baud;
  localparam logic [15:0] c_BIT  = 16'(c_DIV - 1);
  localparam logic [15:0] c_HALF = 16'(c_DIV / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  rx_state_t   r_rx_state;
  logic [1:0]  r_rxs;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;

  logic [9:0]  r_tx_sh;
  logic [3:0]  r_tx_n;
  logic [15:0] r_tx_cnt;

  // Receiver: find the start edge, re-check it at mid-bit, then sample every
  // bit centre. A low stop bit is reported as a framing error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
      r_rxs      <= 2'b11;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_sh    <= 8'h00;
      rx_data    <= 8'h00;
      rx_avail   <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      r_rxs <= {r_rxs[0], uart_rxd};
      if (rx_ack) rx_avail <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rxs[1]) begin
            r_rx_cnt   <= c_HALF;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt != 16'd0) begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end else if (!r_rxs[1]) begin
            r_rx_cnt   <= c_BIT;
            r_rx_bit   <= 3'd0;
            r_rx_state <= S_DATA;
          end else begin
            r_rx_state <= S_IDLE;   // glitch, not a start bit
          end
        end
        S_DATA: begin
          if (r_rx_cnt != 16'd0) begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end else begin
            r_rx_sh  <= {r_rxs[1], r_rx_sh[7:1]};
            r_rx_cnt <= c_BIT;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end
        end
        default: begin
          if (r_rx_cnt != 16'd0) begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end else begin
            rx_data    <= r_rx_sh;
            rx_avail   <= 1'b1;
            rx_error   <= ~r_rxs[1];
            r_rx_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Transmitter: shift {stop, data, start} out LSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      r_tx_sh  <= 10'h3FF;
      r_tx_n   <= 4'd0;
      r_tx_cnt <= 16'd0;
    end else if (!tx_busy) begin
      if (tx_wr) begin
        r_tx_sh  <= {1'b1, tx_data, 1'b0};
        r_tx_n   <= 4'd10;
        r_tx_cnt <= 16'd0;
        tx_busy  <= 1'b1;
      end
    end else if (r_tx_cnt != 16'd0) begin
      r_tx_cnt <= r_tx_cnt - 16'd1;
    end else if (r_tx_n == 4'd0) begin
      tx_busy <= 1'b0;
    end else begin
      uart_txd <= r_tx_sh[0];
      r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
      r_tx_n   <= r_tx_n - 4'd1;
      r_tx_cnt <= c_BIT;
    end
  end

endmodule

// ----------------------------------------------------------------------------
// wb_uart_fifo: top level
// ----------------------------------------------------------------------------
module wb_uart_fifo #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200,
  parameter int CHANNELS = 4,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic [CHANNELS-1:0] uart_rxd,
  output logic [CHANNELS-1:0] uart_txd,
  output logic                irq_o
);

  localparam int               c_DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] c_FULL  = c_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] c_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

  logic                     r_ack;
  logic [7:0]               r_dat;
  logic                     r_irq;
  logic                     w_qual;
  logic                     w_acc;
  logic [3:0]               w_ch;
  logic [1:0]               w_reg;
  logic [7:0]               w_rd_mux;
  logic [CHANNELS-1:0][7:0] w_ch_rd;
  logic [CHANNELS-1:0]      w_ch_irq;
  logic                     w_unused;

  // Counts are FIFO_AW+1 bits wide; LEVEL only has 4 bits per count.
  function automatic logic [3:0] f_sat(input logic [FIFO_AW:0] cnt);
    return (32'(cnt) > 32'd15) ? 4'hF : 4'(cnt);
  endfunction

  assign w_qual   = wb_stb_i & wb_cyc_i;
  // w_acc marks the single edge on which an access takes effect.
  assign w_acc    = w_qual & ~r_ack;
  assign w_ch     = wb_adr_i[7:4];
  assign w_reg    = wb_adr_i[3:2];
  assign wb_ack_o = w_qual & r_ack;
  assign wb_dat_o = {24'h000000, r_dat};
  assign irq_o    = r_irq;
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:8]};

  // Channels that do not exist never match, so they read as zero.
  always_comb begin
    w_rd_mux = 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ch == 4'(i)) w_rd_mux = w_ch_rd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_dat <= wb_we_i ? 8'h00 : w_rd_mux;
      r_irq <= |w_ch_irq;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [7:0]         w_rx_data;
    logic               w_rx_avail;
    logic               w_rx_error;
    logic               w_tx_busy;
    logic               r_rx_ack;
    logic               r_rx_hold;
    logic               r_tx_wr;
    logic               r_tx_wr_d;
    logic [7:0]         r_tx_data;
    logic [7:0]         r_rx_mem [c_DEPTH];
    logic [7:0]         r_tx_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [FIFO_AW:0]   r_rx_cnt, r_tx_cnt;
    logic               r_txovf, r_rxovf, r_rxerr;
    logic [2:0]         r_ctrl;
    logic               w_sel, w_wr, w_rd, w_flush, w_w1c;
    logic               w_rx_cap, w_rx_pop, w_rx_push, w_rx_full, w_rx_ne;
    logic               w_tx_req, w_tx_pop, w_tx_push, w_tx_full, w_tx_empty;

    assign w_sel      = w_acc & (w_ch == 4'(gi));
    assign w_wr       = w_sel & wb_we_i;
    assign w_rd       = w_sel & ~wb_we_i;
    assign w_w1c      = w_wr & (w_reg == 2'd0);
    assign w_flush    = w_wr & (w_reg == 2'd2) & wb_dat_i[7];

    assign w_rx_full  = (r_rx_cnt == c_FULL);
    assign w_rx_ne    = (r_rx_cnt != '0);
    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);

    // rx_avail is still high during the ack pulse and the cycle after it,
    // so it is ignored then to avoid capturing the same byte twice.
    assign w_rx_cap   = w_rx_avail & ~r_rx_ack & ~r_rx_hold;
    assign w_rx_pop   = w_rd & (w_reg == 2'd1) & w_rx_ne;
    assign w_rx_push  = w_rx_cap & (~w_rx_full | w_rx_pop);

    // Two-cycle holdoff after tx_wr covers the core's tx_busy rise latency.
    assign w_tx_req   = w_wr & (w_reg == 2'd1);
    assign w_tx_pop   = ~w_tx_empty & ~w_tx_busy & ~r_tx_wr & ~r_tx_wr_d & ~w_flush;
    assign w_tx_push  = w_tx_req & (~w_tx_full | w_tx_pop);

    assign w_ch_rd[gi] =
        (w_reg == 2'd0) ? {r_txovf, r_rxovf, r_rxerr, 1'b0,
                           w_tx_full, w_tx_empty, w_rx_full, w_rx_ne} :
        (w_reg == 2'd1) ? (w_rx_ne ? r_rx_mem[r_rx_rp] : 8'h00) :
        (w_reg == 2'd2) ? {5'b00000, r_ctrl} :
                          {f_sat(r_tx_cnt), f_sat(r_rx_cnt)};

    assign w_ch_irq[gi] = (r_ctrl[0] & w_rx_ne) | (r_ctrl[1] & w_tx_empty) |
                          (r_ctrl[2] & (r_rxovf | r_rxerr | r_txovf));

    always_ff @(posedge clk) begin
      if (w_rx_push & ~w_flush) r_rx_mem[r_rx_wp] <= w_rx_data;
      if (w_tx_push & ~w_flush) r_tx_mem[r_tx_wp] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rx_ack  <= 1'b0;
        r_rx_hold <= 1'b0;
        r_tx_wr   <= 1'b0;
        r_tx_wr_d <= 1'b0;
        r_tx_data <= 8'h00;
        r_rx_wp   <= '0;
        r_rx_rp   <= '0;
        r_tx_wp   <= '0;
        r_tx_rp   <= '0;
        r_rx_cnt  <= '0;
        r_tx_cnt  <= '0;
        r_txovf   <= 1'b0;
        r_rxovf   <= 1'b0;
        r_rxerr   <= 1'b0;
        r_ctrl    <= 3'b000;
      end else begin
        r_rx_ack  <= w_rx_cap;
        r_rx_hold <= r_rx_ack;
        r_tx_wr   <= w_tx_pop;
        r_tx_wr_d <= r_tx_wr;
        if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rp];

        if (w_flush) begin
          r_rx_wp  <= '0;
          r_rx_rp  <= '0;
          r_tx_wp  <= '0;
          r_tx_rp  <= '0;
          r_rx_cnt <= '0;
          r_tx_cnt <= '0;
        end else begin
          if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
          if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
          if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
          if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
          r_rx_cnt <= r_rx_cnt + (w_rx_push ? c_ONE : '0) - (w_rx_pop ? c_ONE : '0);
          r_tx_cnt <= r_tx_cnt + (w_tx_push ? c_ONE : '0) - (w_tx_pop ? c_ONE : '0);
        end

        // Sticky flags: a new event beats a simultaneous W1C.
        r_txovf <= (w_tx_req & w_tx_full & ~w_tx_pop) |
                   (r_txovf & ~(w_w1c & wb_dat_i[7]));
        r_rxovf <= (w_rx_cap & w_rx_full & ~w_rx_pop) |
                   (r_rxovf & ~(w_w1c & wb_dat_i[6]));
        r_rxerr <= (w_rx_cap & w_rx_error) |
                   (r_rxerr & ~(w_w1c & wb_dat_i[5]));

        if (w_wr && (w_reg == 2'd2)) r_ctrl <= wb_dat_i[2:0];
      end
    end

    uart #(
      .clk_freq(clk_freq),
      .baud    (baud)
    ) u_uart (
      .clk     (clk),
      .reset   (reset),
      .uart_rxd(uart_rxd[gi]),
      .uart_txd(uart_txd[gi]),
      .rx_data (w_rx_data),
      .rx_avail(w_rx_avail),
      .rx_error(w_rx_error),
      .rx_ack  (r_rx_ack),
      .tx_data (r_tx_data),
      .tx_wr   (r_tx_wr),
      .tx_busy (w_tx_busy)
    );
  end

endmodule
`default_nettype wire
